// File: rtl/prbs_test_ctrl.sv
// PRBS link test sequencer: clear -> sync (lock hunt with timeout) -> windowed error measurement.
// Optional macro PRBS_CTRL_CONTINUOUS_EN keeps measuring window after window until stop/reset.
module prbs_test_ctrl #(
    parameter int WIN_LEN  = 1024,
    parameter int SYNC_LEN = 16,
    parameter int TIMEOUT  = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       prbs_error,
    output logic       gen_en,
    output logic       chk_clr,
    output logic [1:0] status,
    output logic       locked,
    output logic       sync_fail,
    output logic       fail,
    output logic [7:0] err_count,
    output logic       window_done
);

    localparam int WIN_W  = $clog2(WIN_LEN + 1);
    localparam int SYNC_W = $clog2(SYNC_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_LEN - 1);
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_LEN - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_SYNC    = 3'd2,
        ST_MEASURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t            state_r;
    state_t            next_s;
    logic [SYNC_W-1:0] run_r;
    logic [TO_W-1:0]   tot_r;
    logic [WIN_W-1:0]  win_r;
    logic [7:0]        acc_r;
    logic [7:0]        acc_inc_s;
    logic              lock_s;
    logic              timeout_s;
    logic              win_end_s;
    logic              win_fire_s;
    logic              to_fire_s;

    logic              gen_en_r;
    logic              chk_clr_r;
    logic [1:0]        status_r;
    logic              locked_r;
    logic              sync_fail_r;
    logic              fail_r;
    logic [7:0]        err_count_r;
    logic              window_done_r;

    // Accumulator step that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic e);
        if (e && (v != 8'hFF)) begin
            sat_inc = v + 8'd1;
        end else begin
            sat_inc = v;
        end
    endfunction

    // Status encoding of a state; CLEAR reports as SYNC.
    function automatic logic [1:0] status_of(input state_t s);
        case (s)
            ST_IDLE:    status_of = 2'b00;
            ST_CLEAR:   status_of = 2'b01;
            ST_SYNC:    status_of = 2'b01;
            ST_MEASURE: status_of = 2'b10;
            ST_DONE:    status_of = 2'b11;
            default:    status_of = 2'b00;
        endcase
    endfunction

    // Per-cycle event decode: lock, sync timeout, window end.
    always_comb begin
        acc_inc_s = sat_inc(acc_r, prbs_error);
        lock_s    = 1'b0;
        timeout_s = 1'b0;
        win_end_s = 1'b0;
        if (state_r == ST_SYNC) begin
            lock_s    = (!prbs_error) && (run_r == SYNC_LAST);
            timeout_s = (tot_r == TO_LAST);
        end else begin
            lock_s    = 1'b0;
            timeout_s = 1'b0;
        end
        if (state_r == ST_MEASURE) begin
            win_end_s = (win_r == WIN_LAST);
        end else begin
            win_end_s = 1'b0;
        end
    end

    // Next-state logic; stop outranks every other request outside IDLE.
    always_comb begin
        next_s     = state_r;
        win_fire_s = 1'b0;
        to_fire_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    next_s = ST_CLEAR;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (stop) begin
                    next_s = ST_IDLE;
                end else begin
                    next_s = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (stop) begin
                    next_s = ST_IDLE;
                end else if (lock_s) begin
                    next_s = ST_MEASURE;
                end else if (timeout_s) begin
                    next_s    = ST_DONE;
                    to_fire_s = 1'b1;
                end else begin
                    next_s = ST_SYNC;
                end
            end
            ST_MEASURE: begin
                if (stop) begin
                    next_s = ST_IDLE;
                end else if (win_end_s) begin
                    win_fire_s = 1'b1;
`ifdef PRBS_CTRL_CONTINUOUS_EN
                    next_s = ST_MEASURE;
`else
                    next_s = ST_DONE;
`endif
                end else begin
                    next_s = ST_MEASURE;
                end
            end
            ST_DONE: begin
                if (stop) begin
                    next_s = ST_IDLE;
                end else if (start) begin
                    next_s = ST_CLEAR;
                end else begin
                    next_s = ST_DONE;
                end
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and result registers; outputs are loaded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            run_r         <= '0;
            tot_r         <= '0;
            win_r         <= '0;
            acc_r         <= 8'd0;
            gen_en_r      <= 1'b0;
            chk_clr_r     <= 1'b0;
            status_r      <= 2'b00;
            locked_r      <= 1'b0;
            sync_fail_r   <= 1'b0;
            fail_r        <= 1'b0;
            err_count_r   <= 8'd0;
            window_done_r <= 1'b0;
        end else begin
            state_r       <= next_s;
            gen_en_r      <= (next_s == ST_CLEAR) || (next_s == ST_SYNC) || (next_s == ST_MEASURE);
            chk_clr_r     <= (next_s == ST_CLEAR);
            status_r      <= status_of(next_s);
            locked_r      <= (next_s == ST_MEASURE);
            window_done_r <= win_fire_s;

            // Counters are only live in their own state and read as zero on entry.
            if (state_r == ST_SYNC) begin
                run_r <= prbs_error ? '0 : (run_r + SYNC_W'(1));
                tot_r <= tot_r + TO_W'(1);
            end else begin
                run_r <= '0;
                tot_r <= '0;
            end
            if ((state_r == ST_MEASURE) && !win_end_s) begin
                win_r <= win_r + WIN_W'(1);
                acc_r <= acc_inc_s;
            end else begin
                win_r <= '0;
                acc_r <= 8'd0;
            end

            if (next_s == ST_CLEAR) begin
                err_count_r <= 8'd0;
                fail_r      <= 1'b0;
                sync_fail_r <= 1'b0;
            end else if (win_fire_s) begin
                err_count_r <= acc_inc_s;
                fail_r      <= (acc_inc_s != 8'd0);
            end else if (to_fire_s) begin
                sync_fail_r <= 1'b1;
                fail_r      <= 1'b1;
            end else begin
                err_count_r <= err_count_r;
            end
        end
    end

    assign gen_en      = gen_en_r;
    assign chk_clr     = chk_clr_r;
    assign status      = status_r;
    assign locked      = locked_r;
    assign sync_fail   = sync_fail_r;
    assign fail        = fail_r;
    assign err_count   = err_count_r;
    assign window_done = window_done_r;

endmodule

// File: tb/tb_prbs_test_ctrl.sv
// Directed self-checking bench for prbs_test_ctrl (WIN_LEN=8, SYNC_LEN=4, TIMEOUT=32,
// plus a WIN_LEN=300 instance for saturation).
module tb_prbs_test_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stop, prbs_error;
    logic       gen_en, chk_clr, locked, sync_fail, fail, window_done;
    logic [1:0] status;
    logic [7:0] err_count;

    logic       start2, prbs_error2;
    logic       gen_en2, chk_clr2, locked2, sync_fail2, fail2, window_done2;
    logic [1:0] status2;
    logic [7:0] err_count2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prbs_test_ctrl #(.WIN_LEN(8), .SYNC_LEN(4), .TIMEOUT(32)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .prbs_error(prbs_error),
        .gen_en(gen_en), .chk_clr(chk_clr), .status(status), .locked(locked),
        .sync_fail(sync_fail), .fail(fail), .err_count(err_count), .window_done(window_done)
    );

    prbs_test_ctrl #(.WIN_LEN(300), .SYNC_LEN(4), .TIMEOUT(32)) dut_sat (
        .clk(clk), .reset(reset), .start(start2), .stop(1'b0), .prbs_error(prbs_error2),
        .gen_en(gen_en2), .chk_clr(chk_clr2), .status(status2), .locked(locked2),
        .sync_fail(sync_fail2), .fail(fail2), .err_count(err_count2), .window_done(window_done2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start pulse, CLEAR, then four clean SYNC cycles -> first MEASURE cycle
    task automatic go_measure();
        prbs_error = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0; prbs_error = 1'b0;
        start2 = 1'b0; prbs_error2 = 1'b0;
        repeat (3) tick();
        checks++;
        if ({gen_en, chk_clr, status, locked, sync_fail, fail, err_count, window_done} !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {gen_en, chk_clr, status, locked, sync_fail, fail, err_count, window_done});
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        checks++;
        if (status !== 2'b00 || gen_en !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset status=%b gen_en=%b exp 00/0", status, gen_en);
        end
    endtask

    task automatic test_nominal();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (chk_clr !== 1'b1 || status !== 2'b01 || gen_en !== 1'b1) begin
            failures++;
            $display("FAIL clear_cycle chk_clr=%b status=%b gen_en=%b exp 1/01/1", chk_clr, status, gen_en);
        end
        tick();
        checks++;
        if (chk_clr !== 1'b0 || status !== 2'b01) begin
            failures++;
            $display("FAIL sync_entry chk_clr=%b status=%b exp 0/01", chk_clr, status);
        end
        repeat (3) tick();
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL early_lock locked=%b exp 0", locked);
        end
        tick();
        checks++;
        if (locked !== 1'b1 || status !== 2'b10) begin
            failures++;
            $display("FAIL lock locked=%b status=%b exp 1/10", locked, status);
        end
        repeat (7) tick();
        checks++;
        if (window_done !== 1'b0 || status !== 2'b10) begin
            failures++;
            $display("FAIL early_window window_done=%b status=%b exp 0/10", window_done, status);
        end
        tick();
`ifdef PRBS_CTRL_CONTINUOUS_EN
        checks++;
        if (window_done !== 1'b1 || err_count !== 8'd0 || status !== 2'b10) begin
            failures++;
            $display("FAIL window_end_cont wd=%b err=%0d status=%b exp 1/0/10", window_done, err_count, status);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
`else
        checks++;
        if (window_done !== 1'b1 || err_count !== 8'd0 || fail !== 1'b0 || status !== 2'b11 ||
            gen_en !== 1'b0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL window_end wd=%b err=%0d fail=%b status=%b gen_en=%b locked=%b exp 1/0/0/11/0/0",
                     window_done, err_count, fail, status, gen_en, locked);
        end
        tick();
        checks++;
        if (window_done !== 1'b0 || status !== 2'b11) begin
            failures++;
            $display("FAIL done_hold wd=%b status=%b exp 0/11", window_done, status);
        end
`endif
    endtask

    task automatic test_errors();
        go_measure();
        for (int k = 1; k <= 8; k++) begin
            prbs_error = (k == 1 || k == 4 || k == 8);
            tick();
        end
        prbs_error = 1'b0;
        checks++;
        if (err_count !== 8'd3 || fail !== 1'b1 || window_done !== 1'b1) begin
            failures++;
            $display("FAIL error_count err=%0d fail=%b wd=%b exp 3/1/1", err_count, fail, window_done);
        end
    endtask

    task automatic test_stop_done();
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        checks++;
        if (status !== 2'b00 || err_count !== 8'd3 || fail !== 1'b1 || chk_clr !== 1'b0) begin
            failures++;
            $display("FAIL stop_in_done status=%b err=%0d fail=%b chk_clr=%b exp 00/3/1/0",
                     status, err_count, fail, chk_clr);
        end
    endtask

    task automatic test_timeout();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (fail !== 1'b0 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL clear_results fail=%b err=%0d exp 0/0", fail, err_count);
        end
        tick();
        for (int k = 1; k <= 31; k++) begin
            prbs_error = (k % 3 == 0);
            tick();
        end
        checks++;
        if (status !== 2'b01 || locked !== 1'b0 || sync_fail !== 1'b0) begin
            failures++;
            $display("FAIL pre_timeout status=%b locked=%b sync_fail=%b exp 01/0/0", status, locked, sync_fail);
        end
        prbs_error = 1'b0;
        tick();
        checks++;
        if (status !== 2'b11 || sync_fail !== 1'b1 || fail !== 1'b1 || gen_en !== 1'b0) begin
            failures++;
            $display("FAIL timeout status=%b sync_fail=%b fail=%b gen_en=%b exp 11/1/1/0",
                     status, sync_fail, fail, gen_en);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_stop_measure();
        go_measure();
        repeat (4) tick();
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        checks++;
        if (status !== 2'b00 || locked !== 1'b0 || gen_en !== 1'b0 || window_done !== 1'b0 ||
            err_count !== 8'd0) begin
            failures++;
            $display("FAIL stop_measure status=%b locked=%b gen_en=%b wd=%b err=%0d exp 00/0/0/0/0",
                     status, locked, gen_en, window_done, err_count);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (window_done !== 1'b0 || status !== 2'b00) begin
                failures++;
                $display("FAIL after_stop k=%0d wd=%b status=%b exp 0/00", k, window_done, status);
            end
        end
    endtask

    task automatic test_continuous();
        go_measure();
        for (int k = 1; k <= 8; k++) begin
            prbs_error = (k == 2 || k == 5);
            tick();
        end
        prbs_error = 1'b0;
        checks++;
        if (window_done !== 1'b1 || err_count !== 8'd2 || fail !== 1'b1 || status !== 2'b10) begin
            failures++;
            $display("FAIL cont_win1 wd=%b err=%0d fail=%b status=%b exp 1/2/1/10",
                     window_done, err_count, fail, status);
        end
        repeat (7) tick();
        checks++;
        if (window_done !== 1'b0) begin
            failures++;
            $display("FAIL cont_mid wd=%b exp 0", window_done);
        end
        tick();
        checks++;
        if (window_done !== 1'b1 || err_count !== 8'd0 || fail !== 1'b0 || status !== 2'b10) begin
            failures++;
            $display("FAIL cont_win2 wd=%b err=%0d fail=%b status=%b exp 1/0/0/10",
                     window_done, err_count, fail, status);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_saturation();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (5) tick();
        checks++;
        if (locked2 !== 1'b1) begin
            failures++;
            $display("FAIL sat_lock locked=%b exp 1", locked2);
        end
        prbs_error2 = 1'b1;
        repeat (299) tick();
        checks++;
        if (window_done2 !== 1'b0) begin
            failures++;
            $display("FAIL sat_early wd=%b exp 0", window_done2);
        end
        tick();
        prbs_error2 = 1'b0;
        checks++;
        if (window_done2 !== 1'b1 || err_count2 !== 8'd255 || fail2 !== 1'b1) begin
            failures++;
            $display("FAIL saturation wd=%b err=%0d fail=%b exp 1/255/1", window_done2, err_count2, fail2);
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        checks++;
        if (status !== 2'b01 || gen_en !== 1'b1) begin
            failures++;
            $display("FAIL mid_sync status=%b gen_en=%b exp 01/1", status, gen_en);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({gen_en, chk_clr, status, locked, sync_fail, fail, err_count, window_done} !== 15'd0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=0",
                     {gen_en, chk_clr, status, locked, sync_fail, fail, err_count, window_done});
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (6) tick();
        checks++;
        if (status !== 2'b00 || window_done !== 1'b0) begin
            failures++;
            $display("FAIL post_reset status=%b wd=%b exp 00/0", status, window_done);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
`ifdef PRBS_CTRL_CONTINUOUS_EN
        test_continuous();
`else
        test_errors();
        test_stop_done();
`endif
        test_timeout();
        test_stop_measure();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prbs_test_ctrl.md
PRBS_TEST_CTRL -- requirements
Module: prbs_test_ctrl

Interface
REQ-001 Parameter WIN_LEN, default 1024: measurement window length in clk cycles (>=2).
REQ-002 Parameter SYNC_LEN, default 16: consecutive error-free cycles required to declare lock (>=1).
REQ-003 Parameter TIMEOUT, default 4096: maximum cycles spent in SYNC before declaring sync failure (>SYNC_LEN).
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  level-sampled request to begin a test; acted on in IDLE or DONE only.
REQ-007 stop  input  1  abort request; acted on in any state other than IDLE.
REQ-008 prbs_error  input  1  per-cycle bit-error flag from the PRBS checker.
REQ-009 gen_en  output  1  enables PRBS generator/checker.
REQ-010 chk_clr  output  1  one-cycle pulse clearing downstream error counters and LED display.
REQ-011 status  output  2  00 IDLE, 01 SYNC (incl. CLEAR), 10 MEASURE, 11 DONE.
REQ-012 locked  output  1  high while lock is held (MEASURE).
REQ-013 sync_fail  output  1  sticky: SYNC timed out.
REQ-014 fail  output  1  sticky: last completed window had err_count>0, or sync_fail.
REQ-015 err_count  output  8  saturating error count of last completed window.
REQ-016 window_done  output  1  one-cycle pulse at the end of each window.

Function
REQ-017 States IDLE, CLEAR, SYNC, MEASURE, DONE; encoding free, status mapping per REQ-011.
REQ-018 IDLE: gen_en=0; start=1 -> CLEAR next cycle.
REQ-019 CLEAR: lasts exactly one cycle; chk_clr=1, gen_en=1; clears fail, sync_fail, err_count, internal counters; -> SYNC.
REQ-020 SYNC: gen_en=1; run counter increments on prbs_error=0, resets to 0 on prbs_error=1; run reaching SYNC_LEN -> MEASURE.
REQ-021 SYNC: total-cycle counter; reaching TIMEOUT without lock -> DONE with sync_fail=1, fail=1; lock and timeout on the same cycle: lock wins.
REQ-022 MEASURE: gen_en=1, locked=1; 8-bit accumulator increments on prbs_error, saturates at 255, never wraps.
REQ-023 MEASURE: after exactly WIN_LEN cycles, err_count <= accumulator including final-cycle error, fail <= (that value !=0), window_done=1 for one cycle, -> DONE.
REQ-024 DONE: gen_en=0, locked=0; results held; start=1 -> CLEAR (new test).
REQ-025 stop=1 in CLEAR, SYNC, MEASURE or DONE -> IDLE next cycle; gen_en, locked, window_done drop; err_count, fail, sync_fail retain last values; partial window discarded.
REQ-026 stop and start asserted together: stop wins.
REQ-027 start while in CLEAR, SYNC or MEASURE is ignored.
REQ-028 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-029 On reset: state IDLE, gen_en=0, chk_clr=0, status=00, locked=0, sync_fail=0, fail=0, err_count=0, window_done=0, all counters 0.
REQ-030 Reset asserted mid-test aborts immediately (asynchronously); no window_done is issued.

Configuration
REQ-031 Macro PRBS_CTRL_CONTINUOUS_EN: when defined, window end in MEASURE updates err_count/fail and pulses window_done but remains in MEASURE, restarting accumulator and window counter the same cycle; only stop or reset exit.
REQ-032 Without PRBS_CTRL_CONTINUOUS_EN: single-window behaviour per REQ-023.

Verification (WIN_LEN=8, SYNC_LEN=4, TIMEOUT=32)
REQ-033 start pulse, prbs_error=0 -> chk_clr one cycle after start, locked after 4 SYNC cycles, window_done 8 cycles later, err_count=0, fail=0, status=11.
REQ-034 prbs_error=1 on 3 MEASURE cycles including the last -> err_count=3, fail=1.
REQ-035 prbs_error=1 every 3rd cycle in SYNC -> no lock; after 32 SYNC cycles status=11, sync_fail=1, fail=1, gen_en=0.
REQ-036 WIN_LEN=300, prbs_error=1 throughout MEASURE -> err_count=255 (saturated).
REQ-037 stop at MEASURE cycle 5 with start also high -> IDLE next cycle, no window_done, prior err_count retained; reset mid-SYNC -> all outputs at REQ-029 values.
REQ-038 With PRBS_CTRL_CONTINUOUS_EN, 2 errors in window 1, 0 in window 2 -> window_done every 8 cycles, err_count 2 then 0, status stays 10.
